// File: rtl/sram_obi_arbiter.sv
// Round-robin OBI arbiter: N masters share one SRAM port; 0-cycle request/grant/response paths.
// Backpressure: a stalled address phase is held until granted; s_req_o drops while the in-order ID FIFO is full.
module sram_obi_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MAX_BURST       = 4,
  parameter int IDX_W           = $clog2(NUM_MASTERS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  input  logic [32*NUM_MASTERS-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_be_i,
  input  logic [32*NUM_MASTERS-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]    m_lock_i,
  output logic [NUM_MASTERS-1:0]    m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  output logic [31:0]               s_addr_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  output logic [31:0]               s_wdata_o,
  input  logic                      s_rvalid_i,
  input  logic [31:0]               s_rdata_i,
  output logic                      resp_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic             hold_valid;
  logic [IDX_W-1:0] hold_idx;
  logic [BC_W-1:0]  burst_cnt;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             any_req, hold_live, found, full, handshake, pop, lock_ext;
  logic [IDX_W-1:0] winner, rr_next, fifo_head;
  logic [BC_W-1:0]  cnt_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A held master that drops its request loses the hold and the search runs normally.
  always_comb begin
    int cand;
    any_req   = |m_req_i;
    hold_live = hold_valid && m_req_i[hold_idx];
    winner    = '0;
    found     = 1'b0;
    cand      = 0;
    if (hold_live) begin
      winner = hold_idx;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cand = int'(rr_ptr) + i;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        if (!found && m_req_i[cand]) begin
          found  = 1'b1;
          winner = IDX_W'(cand);
        end
      end
    end
  end

  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign s_req_o   = rst_ni && any_req && !full;
  assign handshake = s_req_o && s_gnt_i;
  assign fifo_head = fifo_q[rd_ptr];
  assign pop       = s_rvalid_i && (count != '0);
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (any_req && winner == IDX_W'(k)) begin
        s_addr_o   = m_addr_i[32*k +: 32];
        s_we_o     = m_we_i[k];
        s_be_o     = m_be_i[4*k +: 4];
        s_wdata_o  = m_wdata_i[32*k +: 32];
        m_gnt_o[k] = handshake;
      end
      m_rvalid_o[k] = rst_ni && pop && (fifo_head == IDX_W'(k));
    end
  end

  // The burst count only belongs to the master currently owning rr_ptr.
  assign cnt_eff  = (winner == rr_ptr) ? burst_cnt : '0;
  assign lock_ext = m_lock_i[winner] && (cnt_eff < BC_W'(MAX_BURST - 1));
  assign rr_next  = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      hold_valid <= 1'b0;
      hold_idx   <= '0;
      burst_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (handshake) begin
        hold_valid <= 1'b0;
        wr_ptr     <= ptr_inc(wr_ptr);
        if (lock_ext) begin
          rr_ptr    <= winner;
          burst_cnt <= cnt_eff + BC_W'(1);
        end else begin
          rr_ptr    <= rr_next;
          burst_cnt <= '0;
        end
      end else if (s_req_o) begin
        hold_valid <= 1'b1;
        hold_idx   <= winner;
      end else if (hold_valid && !m_req_i[hold_idx]) begin
        hold_valid <= 1'b0;
      end

      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (handshake && !pop)      count <= count + CNT_W'(1);
      else if (!handshake && pop) count <= count - CNT_W'(1);

      if (s_rvalid_i && count == '0) resp_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) fifo_q[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Bench for sram_obi_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_sram_obi_arbiter;
  localparam int NM = 2;
  localparam int MO = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic [NM-1:0] m_req = '0, m_we = '0, m_lock = '0;
  logic [NM-1:0] m_gnt, m_rvalid;
  logic [32*NM-1:0] m_addr = '0, m_wdata = '0;
  logic [4*NM-1:0] m_be = '0;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic s_req, s_we, resp_err;
  logic [3:0] s_be;
  logic s_gnt = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;

  sram_obi_arbiter #(.NUM_MASTERS(NM), .MAX_OUTSTANDING(MO), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr),
    .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata), .m_lock_i(m_lock),
    .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .s_req_o(s_req), .s_gnt_i(s_gnt),
    .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .resp_err_o(resp_err));

  int n_checks = 0, n_fail = 0;

  // Reference model: owner queue, priority pointer, held master, lock streak.
  int rr = 0, hold = -1, streak = 0;
  int owners[$];
  bit err_m = 1'b0;
  // SRAM responder: in-order due cycles and data.
  int cyc = 0, lat = 1, last_due = -1;
  bit spur = 1'b0;
  int rq_due[$];
  logic [31:0] rq_dat[$];
  // Model outputs for the current cycle.
  int e_win;
  logic e_sreq, e_we;
  logic [NM-1:0] e_gnt, e_rv;
  logic [31:0] e_addr, e_wdata;
  logic [3:0] e_be;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_eval();
    e_win = -1;
    if (hold >= 0 && m_req[hold]) e_win = hold;
    else for (int i = 0; i < NM; i++) if (e_win < 0 && m_req[(rr + i) % NM]) e_win = (rr + i) % NM;
    e_sreq = rst_n && (m_req != '0) && (owners.size() < MO);
    e_gnt = '0;
    if (e_sreq && s_gnt) e_gnt[e_win] = 1'b1;
    e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
    if (e_win >= 0) begin
      e_addr = m_addr[e_win*32 +: 32]; e_we = m_we[e_win];
      e_be = m_be[e_win*4 +: 4]; e_wdata = m_wdata[e_win*32 +: 32];
    end
    e_rv = '0;
    if (rst_n && s_rvalid && owners.size() > 0) e_rv[owners[0]] = 1'b1;
  endtask

  task automatic model_commit();
    int run, due;
    bit had;
    had = owners.size() > 0;
    if (!rst_n) begin
      rr = 0; hold = -1; streak = 0; owners.delete(); err_m = 1'b0;
    end else begin
      if (e_sreq && s_gnt) begin
        run = (e_win == rr) ? streak : 0;
        owners.push_back(e_win);
        if (m_lock[e_win] && run < MB - 1) begin rr = e_win; streak = run + 1; end
        else begin rr = (e_win + 1) % NM; streak = 0; end
        hold = -1;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq_due.push_back(due);
        rq_dat.push_back(data_of(e_addr));
      end else if (e_sreq) hold = e_win;
      else if (hold >= 0 && !m_req[hold]) hold = -1;
      if (s_rvalid) begin
        if (had) void'(owners.pop_front());
        else err_m = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
    s_rvalid = spur;
    s_rdata = '0;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      s_rvalid = 1'b1;
      s_rdata = rq_dat.pop_front();
      void'(rq_due.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_req = '0; m_lock = '0; s_gnt = 1'b0; spur = 1'b0;
    tick(); tick();
    rq_due.delete(); rq_dat.delete(); last_due = -1;
    s_rvalid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_sreq got=%b exp=0", s_req); end
    n_checks++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got=%b exp=00", m_gnt); end
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=00", m_rvalid); end
    tick();
    rst_n = 1'b1; m_req = '0; s_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL idle_sreq got=%b exp=0", s_req); end
    n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL idle_addr got=%h exp=0", s_addr); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", resp_err); end
    tick();
    // Reset with one transaction in flight: its late response is orphaned.
    lat = 3; m_addr[31:0] = 32'h0000_0400; m_req = 2'b01; s_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=01", m_gnt); end
    tick();
    m_req = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL midrst_rvalid got=%b exp=00", m_rvalid); end
    tick();
    @(negedge clk);
    n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL midrst_err got=%b exp=1", resp_err); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    lat = 1; m_addr = {32'h1234_0000, 32'h8000_0010}; m_we = '0; m_be = '1; m_req = 2'b01; s_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", m_gnt); end
    n_checks++; if (s_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL single_addr got=%h exp=80000010", s_addr); end
    tick();
    m_req = '0;
    @(negedge clk);
    n_checks++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL single_rvalid got=%b exp=01", m_rvalid); end
    n_checks++; if (m_rdata !== data_of(32'h8000_0010)) begin n_fail++; $display("FAIL single_rdata got=%h exp=%h", m_rdata, data_of(32'h8000_0010)); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp, prev;
    do_reset();
    lat = 1; m_req = 2'b11; m_lock = '0; s_gnt = 1'b1; prev = 2'b00;
    for (int c = 0; c < 8; c++) begin
      exp = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_checks++; if (m_gnt !== exp) begin n_fail++; $display("FAIL contention_gnt c=%0d got=%b exp=%b", c, m_gnt, exp); end
      n_checks++; if (m_rvalid !== prev) begin n_fail++; $display("FAIL contention_rvalid c=%0d got=%b exp=%b", c, m_rvalid, prev); end
      prev = exp;
      tick();
    end
    m_req = '0;
    @(negedge clk);
    n_checks++; if (m_rvalid !== prev) begin n_fail++; $display("FAIL contention_last got=%b exp=%b", m_rvalid, prev); end
    tick();
  endtask

  task automatic test_burst();
    logic [1:0] exp [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    do_reset();
    lat = 1; m_req = 2'b11; m_lock = 2'b10; s_gnt = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_checks++; if (m_gnt !== exp[c]) begin n_fail++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, m_gnt, exp[c]); end
      tick();
    end
    m_req = '0; m_lock = '0;
    tick(); tick();
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1; m_addr = {32'hB000_0004, 32'hA000_0000}; m_req = 2'b01; s_gnt = 1'b1;
    tick();
    s_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) m_req = 2'b11;
      @(negedge clk);
      n_checks++; if (s_addr !== 32'hA000_0000 || m_gnt !== 2'b00 || s_req !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold c=%0d got addr=%h gnt=%b req=%b exp addr=a0000000 gnt=00 req=1", c, s_addr, m_gnt, s_req); end
      tick();
    end
    s_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL stall_release got=%b exp=01", m_gnt); end
    tick();
    @(negedge clk);
    n_checks++; if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL stall_next got=%b exp=10", m_gnt); end
    tick();
    m_req = '0;
    tick(); tick();
  endtask

  task automatic test_fifo_full();
    logic sreq_exp [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    logic rv_exp [10]   = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [31:0] rd_addr [4] = '{32'h100, 32'h104, 32'h110, 32'h114};
    int k;
    do_reset();
    lat = 3; m_req = 2'b01; s_gnt = 1'b1; k = 0;
    for (int c = 0; c < 10; c++) begin
      m_addr[31:0] = 32'h100 + 32'(4 * c);
      if (c >= 6) m_req = '0;
      @(negedge clk);
      n_checks++; if (s_req !== sreq_exp[c]) begin n_fail++; $display("FAIL full_sreq c=%0d got=%b exp=%b", c, s_req, sreq_exp[c]); end
      n_checks++; if (m_rvalid !== {1'b0, rv_exp[c]}) begin n_fail++; $display("FAIL full_rvalid c=%0d got=%b exp=0%b", c, m_rvalid, rv_exp[c]); end
      if (rv_exp[c] && k < 4) begin
        n_checks++; if (m_rdata !== data_of(rd_addr[k])) begin n_fail++; $display("FAIL full_order c=%0d got=%h exp=%h", c, m_rdata, data_of(rd_addr[k])); end
        k++;
      end
      tick();
    end
  endtask

  task automatic test_spurious();
    do_reset();
    s_rvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL spur_rvalid got=%b exp=00", m_rvalid); end
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky c=%0d got=%b exp=1", c, resp_err); end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL spur_clear got=%b exp=0", resp_err); end
    tick();
  endtask

  task automatic test_random();
    logic [NM-1:0] pend;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      lat = $urandom_range(1, 3);
      for (int m = 0; m < NM; m++) begin
        if (pend[m] && $urandom_range(0, 49) != 0) continue;
        m_req[m] = ($urandom_range(0, 2) != 0);
        m_addr[m*32 +: 32] = $urandom; m_wdata[m*32 +: 32] = $urandom;
        m_we[m] = $urandom_range(0, 1); m_be[m*4 +: 4] = 4'($urandom_range(0, 15));
      end
      m_lock = NM'($urandom_range(0, (1 << NM) - 1)) & NM'($urandom_range(0, (1 << NM) - 1));
      s_gnt = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_eval();
      n_checks++; if (m_gnt !== e_gnt || s_req !== e_sreq)
        begin n_fail++; $display("FAIL rand_grant c=%0d got gnt=%b req=%b exp gnt=%b req=%b", c, m_gnt, s_req, e_gnt, e_sreq); end
      n_checks++; if ({s_addr, s_we, s_be, s_wdata} !== {e_addr, e_we, e_be, e_wdata})
        begin n_fail++; $display("FAIL rand_fwd c=%0d got addr=%h we=%b be=%h wd=%h exp addr=%h we=%b be=%h wd=%h", c, s_addr, s_we, s_be, s_wdata, e_addr, e_we, e_be, e_wdata); end
      n_checks++; if (m_rvalid !== e_rv) begin n_fail++; $display("FAIL rand_rvalid c=%0d got=%b exp=%b", c, m_rvalid, e_rv); end
      if (e_rv != '0) begin
        n_checks++; if (m_rdata !== s_rdata) begin n_fail++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, m_rdata, s_rdata); end
      end
      n_checks++; if (resp_err !== err_m) begin n_fail++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, resp_err, err_m); end
      pend = m_req & ~e_gnt;
      tick();
    end
    m_req = '0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_stall();
    test_fifo_full();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
